pipe_fetch: RTL

PIPE_FETCH -- requirements
Module: pipe_fetch

---
 rtl/pipe_fetch_pkg.sv | 23 ++
 rtl/pipe_fetch_if.sv | 26 ++
 rtl/pipe_ifid_reg.sv | 51 +++++
 rtl/pipe_fetch.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// vector, NOP word and next-PC select codes.
package pipe_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  function automatic logic [31:0] pc_plus4(input logic [31:0] p);
    return p + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_fetch_if.sv
// Signal bundle between the fetch stage, instruction memory and the ID stage.
interface pipe_fetch_if;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] ra;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dpc4;
  logic [31:0] inst;
  logic        dvalid;
  logic [31:0] pc;

  modport master (
    input  nostall, pcsource, bpc, jpc, ra, imem_ack, imem_rdata,
    output imem_req, imem_addr, dpc4, inst, dvalid, pc
  );

  modport slave (
    output nostall, pcsource, bpc, jpc, ra, imem_ack, imem_rdata,
    input  imem_req, imem_addr, dpc4, inst, dvalid, pc
  );
endinterface

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register: load takes priority over clear; clear turns the
// slot into a NOP bubble but keeps dpc4.
module pipe_ifid_reg
  import pipe_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] dpc4_in,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;

  always_comb begin
    inst_d   = inst_q;
    dpc4_d   = dpc4_q;
    dvalid_d = dvalid_q;
    if (load) begin
      inst_d   = inst_in;
      dpc4_d   = dpc4_in;
      dvalid_d = 1'b1;
    end else if (clear) begin
      inst_d   = NOP;
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q   <= NOP;
      dpc4_q   <= 32'h0000_0000;
      dvalid_q <= 1'b0;
    end else begin
      inst_q   <= inst_d;
      dpc4_q   <= dpc4_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign inst   = inst_q;
  assign dpc4   = dpc4_q;
  assign dvalid = dvalid_q;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch stage: PC, one-word hold buffer for stalled returns, and
// a deferred redirect so a branch resolved before its delay slot arrives still lands.
module pipe_fetch
  import pipe_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pipe_fetch_if.master fif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic         redir_pending_q, redir_pending_d;
  logic [31:0]  redir_tgt_q, redir_tgt_d;

  logic        accept, consume, redirect, load, clear;
  logic [31:0] sel_tgt, next_pc, load_word;
  logic [31:0] ifid_inst, ifid_dpc4;
  logic        ifid_dvalid;

  always_comb begin
    accept   = ~ifid_dvalid | fif.nostall;
    consume  = ifid_dvalid & fif.nostall;
    redirect = consume && (fif.pcsource != PCS_SEQ);

    case (fif.pcsource)
      PCS_BR:  sel_tgt = fif.bpc;
      PCS_JR:  sel_tgt = fif.ra;
      PCS_J:   sel_tgt = fif.jpc;
      default: sel_tgt = pc_plus4(pc_q);
    endcase

    if (redirect)             next_pc = sel_tgt;
    else if (redir_pending_q) next_pc = redir_tgt_q;
    else                      next_pc = pc_plus4(pc_q);
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    hold_d          = hold_q;
    redir_pending_d = redir_pending_q;
    redir_tgt_d     = redir_tgt_q;
    load            = 1'b0;
    load_word       = hold_q;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (fif.imem_ack) begin
          if (accept) begin
            load      = 1'b1;
            load_word = fif.imem_rdata;
          end else begin
            hold_d  = fif.imem_rdata;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (accept) begin
          load    = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect seen without a load must wait for the delay-slot word.
    if (load) begin
      pc_d            = next_pc;
      redir_pending_d = 1'b0;
    end else if (redirect) begin
      redir_pending_d = 1'b1;
      redir_tgt_d     = sel_tgt;
    end

    clear = consume & ~load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_VECTOR;
      hold_q          <= 32'h0000_0000;
      redir_pending_q <= 1'b0;
      redir_tgt_q     <= 32'h0000_0000;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      hold_q          <= hold_d;
      redir_pending_q <= redir_pending_d;
      redir_tgt_q     <= redir_tgt_d;
    end
  end

  pipe_ifid_reg u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .clear   (clear),
    .inst_in (load_word),
    .dpc4_in (pc_plus4(pc_q)),
    .inst    (ifid_inst),
    .dpc4    (ifid_dpc4),
    .dvalid  (ifid_dvalid)
  );

  assign fif.imem_req  = (state_q == ST_FETCH);
  assign fif.imem_addr = pc_q;
  assign fif.pc        = pc_q;
  assign fif.inst      = ifid_inst;
  assign fif.dpc4      = ifid_dpc4;
  assign fif.dvalid    = ifid_dvalid;

endmodule
